// File: rtl/round_sequencer_pkg.sv
// Shared types and constants for the typing-test round sequencer.
package round_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        PLAY   = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam int BCD_W     = 4;
    localparam int SCORE_MAX = 99;
    localparam int ERR_MAX   = 15;

    // Index of the target digit currently being typed (0 = leftmost).
    typedef logic [1:0] pos_t;

    // Pick target digit p out of a packed word; position 0 sits in [15:12].
    function automatic logic [BCD_W-1:0] digit_at(input logic [15:0] word, input pos_t p);
        logic [BCD_W-1:0] d;
        case (p)
            2'd0:    d = word[15:12];
            2'd1:    d = word[11:8];
            2'd2:    d = word[7:4];
            default: d = word[3:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/round_sequencer_bcd2_counter.sv
// Two-digit BCD counter with load, saturating increment and saturating decrement.
module bcd2_counter
    import round_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [2*BCD_W-1:0] load_val,
    input  logic               inc,
    input  logic               dec,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones
);

    logic at_max;
    logic at_min;

    assign at_max = (tens == 4'd9) && (ones == 4'd9);
    assign at_min = (tens == 4'd0) && (ones == 4'd0);

    // Counter register: load beats inc beats dec; ones borrows/carries into tens.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (load) begin
            {tens, ones} <= load_val;
        end else if (inc && !at_max) begin
            if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end else if (dec && !at_min) begin
            if (ones == 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Typing-test round sequencer: target loading, key matching, countdown timer and result display.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int ROUND_SECONDS = 30,
    parameter int HOLD_SECONDS  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        one_hz_tick,
    input  logic        button_pressed,
    input  logic [3:0]  dec,
    input  logic [15:0] rand_digits,
    output logic [15:0] target_digits,
    output logic [3:0]  target_en,
    output logic [3:0]  ssd_tens,
    output logic [3:0]  ssd_ones,
    output logic [1:0]  ssd_en,
    output logic [6:0]  score,
    output logic [3:0]  errors,
    output logic        round_active
);

    localparam logic [7:0] ROUND_BCD = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10)};

    state_t     state_q, state_d;
    pos_t       pos_q;
    logic       btn_q, btn_qq, key_evt;
    logic [3:0] hold_q;
    logic [3:0] timer_tens, timer_ones, score_tens, score_ones;
    logic       timer_load, timer_dec, score_clr, score_inc;
    logic       err_clr, err_inc, hold_load, hold_dec, tgt_load, adv;
    logic       match, tick_to_zero, timer_zero;

    assign key_evt      = btn_q & ~btn_qq;
    assign match        = key_evt && (dec == digit_at(target_digits, pos_q));
    assign timer_zero   = (timer_tens == 4'd0) && (timer_ones == 4'd0);
    assign tick_to_zero = one_hz_tick && (timer_tens == 4'd0) && (timer_ones == 4'd1);

    bcd2_counter u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (ROUND_BCD),
        .inc      (1'b0),
        .dec      (timer_dec),
        .tens     (timer_tens),
        .ones     (timer_ones)
    );

    bcd2_counter u_score (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (score_clr),
        .load_val (8'h00),
        .inc      (score_inc),
        .dec      (1'b0),
        .tens     (score_tens),
        .ones     (score_ones)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle control strobes; a tick reaching 00 outranks any key.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        err_clr    = 1'b0;
        err_inc    = 1'b0;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;
        tgt_load   = 1'b0;
        adv        = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_evt) begin
                    score_clr  = 1'b1;
                    err_clr    = 1'b1;
                    timer_load = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                tgt_load  = 1'b1;
                timer_dec = one_hz_tick;
                state_d   = PLAY;
            end
            PLAY: begin
                timer_dec = one_hz_tick;
                if (tick_to_zero || timer_zero) begin
                    hold_load = 1'b1;
                    state_d   = RESULT;
                end else if (match) begin
                    adv = 1'b1;
                    if (pos_q == 2'd3) begin
                        score_inc = 1'b1;
                        state_d   = LOAD;
                    end
                end else if (key_evt) begin
                    err_inc = 1'b1;
                end
            end
            RESULT: begin
                hold_dec = one_hz_tick && (hold_q != 4'd0);
                if (key_evt && hold_q == 4'd0) begin
                    score_clr  = 1'b1;
                    err_clr    = 1'b1;
                    timer_load = 1'b1;
                    state_d    = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: key edge detector, targets, position, error/score counts, hold timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q         <= 1'b0;
            btn_qq        <= 1'b0;
            target_digits <= '0;
            target_en     <= '0;
            pos_q         <= '0;
            errors        <= '0;
            score         <= '0;
            hold_q        <= '0;
            round_active  <= 1'b0;
        end else begin
            btn_q        <= button_pressed;
            btn_qq       <= btn_q;
            round_active <= (state_d == PLAY);

            if (tgt_load) begin
                target_digits <= rand_digits;
                pos_q         <= '0;
                target_en     <= 4'b1111;
            end else if (adv) begin
                target_en[~pos_q] <= 1'b0;
                pos_q             <= pos_q + 2'd1;
            end
            if (hold_load) target_en <= 4'b0000;

            if (err_clr)                             errors <= '0;
            else if (err_inc && errors != 4'(ERR_MAX)) errors <= errors + 4'd1;

            if (score_clr)                                score <= '0;
            else if (score_inc && score != 7'(SCORE_MAX)) score <= score + 7'd1;

            if (hold_load)     hold_q <= 4'(HOLD_SECONDS);
            else if (hold_dec) hold_q <= hold_q - 4'd1;
        end
    end

    // SSD driver: timer while a round runs, score in RESULT, blank in IDLE; zero tens blanked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ssd_tens <= '0;
            ssd_ones <= '0;
            ssd_en   <= 2'b00;
        end else begin
            case (state_q)
                LOAD, PLAY: begin
                    ssd_tens <= timer_tens;
                    ssd_ones <= timer_ones;
                    ssd_en   <= {timer_tens != 4'd0, 1'b1};
                end
                RESULT: begin
                    ssd_tens <= score_tens;
                    ssd_ones <= score_ones;
                    ssd_en   <= {score_tens != 4'd0, 1'b1};
                end
                default: begin
                    ssd_tens <= '0;
                    ssd_ones <= '0;
                    ssd_en   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer (ROUND_SECONDS=30, HOLD_SECONDS=3).
module tb_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        one_hz_tick;
    logic        button_pressed;
    logic [3:0]  dec;
    logic [15:0] rand_digits;
    logic [15:0] target_digits;
    logic [3:0]  target_en;
    logic [3:0]  ssd_tens;
    logic [3:0]  ssd_ones;
    logic [1:0]  ssd_en;
    logic [6:0]  score;
    logic [3:0]  errors;
    logic        round_active;

    int n_checks = 0;
    int n_errors = 0;

    round_sequencer #(.ROUND_SECONDS(30), .HOLD_SECONDS(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .one_hz_tick    (one_hz_tick),
        .button_pressed (button_pressed),
        .dec            (dec),
        .rand_digits    (rand_digits),
        .target_digits  (target_digits),
        .target_en      (target_en),
        .ssd_tens       (ssd_tens),
        .ssd_ones       (ssd_ones),
        .ssd_en         (ssd_en),
        .score          (score),
        .errors         (errors),
        .round_active   (round_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n cycles; inputs change 1 time unit after the rising edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a key for `hold` cycles, release, and let the design settle.
    task automatic press(input logic [3:0] d, input int hold);
        dec            = d;
        button_pressed = 1'b1;
        cycles(hold);
        button_pressed = 1'b0;
        cycles(4);
    endtask

    task automatic tick();
        one_hz_tick = 1'b1;
        cycles(1);
        one_hz_tick = 1'b0;
        cycles(2);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_active"}, 32'(round_active), 32'd0);
        check({tag, "_ssd_en"}, 32'(ssd_en), 32'b00);
        check({tag, "_score"}, 32'(score), 32'd0);
        check({tag, "_errors"}, 32'(errors), 32'd0);
        check({tag, "_tgt_en"}, 32'(target_en), 32'b0000);
    endtask

    task automatic check_ssd(input string tag, input int t, input int o, input logic [1:0] en);
        check({tag, "_tens"}, 32'(ssd_tens), 32'(t));
        check({tag, "_ones"}, 32'(ssd_ones), 32'(o));
        check({tag, "_en"}, 32'(ssd_en), 32'(en));
    endtask

    initial begin
        rst_n          = 1'b0;
        one_hz_tick    = 1'b0;
        button_pressed = 1'b0;
        dec            = 4'd0;
        rand_digits    = 16'h3719;
        cycles(3);
        check_idle("reset");
        check("reset_tgt", 32'(target_digits), 32'h0);
        rst_n = 1'b1;
        cycles(2);

        // Start a round from IDLE; key value is irrelevant.
        press(4'd0, 3);
        check("start_active", 32'(round_active), 32'd1);
        check("start_tgt", 32'(target_digits), 32'h3719);
        check("start_tgt_en", 32'(target_en), 32'b1111);
        check_ssd("start_ssd", 3, 0, 2'b11);

        // Wrong key counts an error and does not advance.
        press(4'd5, 3);
        check("miss_errors", 32'(errors), 32'd1);
        check("miss_tgt_en", 32'(target_en), 32'b1111);

        // Held key advances exactly once.
        press(4'd3, 50);
        check("held_tgt_en", 32'(target_en), 32'b0111);
        rand_digits = 16'h2468;
        press(4'd7, 3);
        check("p7_tgt_en", 32'(target_en), 32'b0011);
        press(4'd1, 3);
        check("p1_tgt_en", 32'(target_en), 32'b0001);
        press(4'd9, 3);
        check("word_score", 32'(score), 32'd1);
        check("word_tgt", 32'(target_digits), 32'h2468);
        check("word_tgt_en", 32'(target_en), 32'b1111);
        check("word_errors", 32'(errors), 32'd1);

        // Reset mid-PLAY.
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
        check_idle("midrst");

        // Full countdown with no keys.
        rand_digits = 16'h3719;
        press(4'd8, 3);
        for (int i = 1; i < 30; i++) begin
            tick();
            check_ssd($sformatf("cd%0d", 30 - i), (30 - i) / 10, (30 - i) % 10,
                      (30 - i) >= 10 ? 2'b11 : 2'b01);
        end
        tick();
        check("cd_end_active", 32'(round_active), 32'd0);
        check("cd_end_tgt_en", 32'(target_en), 32'b0000);
        check_ssd("cd_end_ssd", 0, 0, 2'b01);

        // RESULT hold: keys ignored until three ticks have elapsed.
        press(4'd3, 3);
        check("hold3_active", 32'(round_active), 32'd0);
        tick();
        tick();
        press(4'd3, 3);
        check("hold1_active", 32'(round_active), 32'd0);
        tick();
        press(4'd3, 3);
        check("restart_active", 32'(round_active), 32'd1);
        check("restart_score", 32'(score), 32'd0);
        check("restart_errors", 32'(errors), 32'd0);
        check_ssd("restart_ssd", 3, 0, 2'b11);

        // Score one word, then type three digits of the next and run the clock to 01.
        press(4'd3, 3);
        press(4'd7, 3);
        press(4'd1, 3);
        press(4'd9, 3);
        check("race_pre_score", 32'(score), 32'd1);
        press(4'd3, 3);
        press(4'd7, 3);
        press(4'd1, 3);
        check("race_pre_tgt_en", 32'(target_en), 32'b0001);
        for (int i = 0; i < 29; i++) tick();
        check_ssd("race_at01", 0, 1, 2'b01);

        // Completing key event and final tick in the same cycle: tick wins.
        dec            = 4'd9;
        button_pressed = 1'b1;
        cycles(1);
        one_hz_tick = 1'b1;
        cycles(1);
        one_hz_tick = 1'b0;
        cycles(2);
        button_pressed = 1'b0;
        cycles(3);
        check("race_active", 32'(round_active), 32'd0);
        check("race_score", 32'(score), 32'd1);
        check("race_tgt_en", 32'(target_en), 32'b0000);
        check_ssd("race_ssd", 0, 1, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
